// File: rtl/dma_sched_pkg.sv
// -----------------------------------------------------------------------------
// dma_sched_pkg
// Shared types and constants for the ping/pong AXI DMA scheduler:
//   - state_e   : scheduler FSM states
//   - dma_reg_e : logical DMA register selector
//   - wr_req_t  : one AXI-Lite register write (address + data)
//   - Xilinx AXI DMA simple-mode register offsets for MM2S and S2MM
//   - control/status words written to DMACR / DMASR
// -----------------------------------------------------------------------------
package dma_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CR,
    ST_WR_ADDR,
    ST_WR_LEN,
    ST_WAIT_IRQ,
    ST_WR_SR,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    REG_CR,
    REG_SR,
    REG_ADDR,
    REG_LEN
  } dma_reg_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_req_t;

  // MM2S channel, simple mode
  localparam logic [31:0] MM2S_DMACR  = 32'h0000_0000;
  localparam logic [31:0] MM2S_DMASR  = 32'h0000_0004;
  localparam logic [31:0] MM2S_SA     = 32'h0000_0018;
  localparam logic [31:0] MM2S_LENGTH = 32'h0000_0028;

  // S2MM channel, simple mode
  localparam logic [31:0] S2MM_DMACR  = 32'h0000_0030;
  localparam logic [31:0] S2MM_DMASR  = 32'h0000_0034;
  localparam logic [31:0] S2MM_DA     = 32'h0000_0048;
  localparam logic [31:0] S2MM_LENGTH = 32'h0000_0058;

  // RS (run) + IOC_IrqEn
  localparam logic [31:0] DMACR_RUN_IOC = 32'h0000_1001;
  // Write-1-to-clear of the IOC interrupt flag
  localparam logic [31:0] DMASR_IOC_CLR = 32'h0000_1000;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Byte offset of a logical register within the selected channel.
  function automatic logic [31:0] reg_offset(input logic s2mm, input dma_reg_e r);
    logic [31:0] off;
    case (r)
      REG_CR:   off = s2mm ? S2MM_DMACR  : MM2S_DMACR;
      REG_SR:   off = s2mm ? S2MM_DMASR  : MM2S_DMASR;
      REG_ADDR: off = s2mm ? S2MM_DA     : MM2S_SA;
      REG_LEN:  off = s2mm ? S2MM_LENGTH : MM2S_LENGTH;
      default:  off = '0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/dma_pingpong_sched_if.sv
// -----------------------------------------------------------------------------
// dma_pingpong_sched_if
// AXI4-Lite write-only channel bundle (AW, W, B) used between the scheduler
// and the AXI-Lite interconnect.
//   master : drives awaddr/awvalid, wdata/wstrb/wvalid, bready
//   slave  : drives awready, wready, bresp/bvalid
// -----------------------------------------------------------------------------
interface dma_pingpong_sched_if;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axil_wr_master.sv
// -----------------------------------------------------------------------------
// axil_wr_master
// Issues a single AXI4-Lite register write per i_start pulse.
//   aclk, aresetn : clock, asynchronous active-low reset
//   i_start       : launch a write with i_req (ignored while one is in flight)
//   i_req         : address and data of the write, captured on i_start
//   o_done        : B handshake with OKAY response (combinational, 1 cycle)
//   o_err         : B handshake with any other response (combinational, 1 cycle)
//   m_axil        : AW/W/B master port
// AW and W are raised together and each drops on its own handshake, so the
// slave may accept them in either order or in the same cycle. bready stays
// high for the whole transaction and its fall marks the end of the write.
// -----------------------------------------------------------------------------
module axil_wr_master
  import dma_sched_pkg::*;
(
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 i_start,
  input  wr_req_t              i_req,
  output logic                 o_done,
  output logic                 o_err,
  dma_pingpong_sched_if.master m_axil
);

  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        w_b_fire;

  assign w_b_fire = r_bready & m_axil.bvalid;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register in this block samples pre-edge values regardless of order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else if (i_start && !r_bready) begin
      r_awaddr  <= i_req.addr;
      r_wdata   <= i_req.data;
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_bready  <= 1'b1;
    end else begin
      if (r_awvalid && m_axil.awready) r_awvalid <= 1'b0;
      if (r_wvalid && m_axil.wready)   r_wvalid  <= 1'b0;
      // A response closes the transaction outright; a slave that answers
      // early must not leave a stale valid behind.
      if (w_b_fire) begin
        r_bready  <= 1'b0;
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
      end
    end
  end

  assign m_axil.awaddr  = r_awaddr;
  assign m_axil.awvalid = r_awvalid;
  assign m_axil.wdata   = r_wdata;
  assign m_axil.wstrb   = 4'hF;
  assign m_axil.wvalid  = r_wvalid;
  assign m_axil.bready  = r_bready;

  assign o_done = w_b_fire & (m_axil.bresp == RESP_OKAY);
  assign o_err  = w_b_fire & (m_axil.bresp != RESP_OKAY);

endmodule

// File: rtl/dma_pingpong_sched.sv
// -----------------------------------------------------------------------------
// dma_pingpong_sched
// Drives one Xilinx AXI DMA channel (simple mode) over AXI4-Lite, alternating
// between a ping and a pong buffer without processor involvement.
//   aclk, aresetn         : clock, asynchronous active-low reset
//   enable                : 1 = keep looping; 0 = stop after the current buffer
//   ping_addr, pong_addr  : buffer byte addresses, sampled at each ADDR write
//   xfer_len              : bytes per buffer, sampled at each LENGTH write
//   dma_irq               : DMA channel interrupt (level)
//   buf_done, buf_idx     : one-cycle completion pulse and the buffer it names
//   busy                  : high outside IDLE and ERROR
//   error                 : sticky, set by a non-OKAY write response
//   m_axil                : AXI4-Lite write master towards the DMA registers
// Sequence: DMACR once, then per buffer ADDR, LENGTH, wait irq, DMASR W1C.
// -----------------------------------------------------------------------------
module dma_pingpong_sched
  import dma_sched_pkg::*;
#(
  parameter logic [31:0] REG_BASE = 32'h4000_0000,
  parameter bit          DIR_S2MM = 1'b1,
  parameter int          LEN_W    = 26
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic [31:0]          ping_addr,
  input  logic [31:0]          pong_addr,
  input  logic [LEN_W-1:0]     xfer_len,
  input  logic                 dma_irq,
  output logic                 buf_done,
  output logic                 buf_idx,
  output logic                 busy,
  output logic                 error,
  dma_pingpong_sched_if.master m_axil
);

  state_e      r_state;
  logic        r_cur_buf;
  logic        r_start;
  wr_req_t     r_req;
  logic        r_buf_done;
  logic        r_buf_idx;
  logic        r_busy;
  logic        r_error;

  logic        w_wr_done;
  logic        w_wr_err;
  logic [31:0] w_len_ext;

  assign w_len_ext = {{(32-LEN_W){1'b0}}, xfer_len};

  function automatic wr_req_t make_req(input dma_reg_e r, input logic [31:0] d);
    wr_req_t q;
    q.addr = REG_BASE + reg_offset(DIR_S2MM, r);
    q.data = d;
    return q;
  endfunction

  function automatic wr_req_t addr_req(input logic which);
    return make_req(REG_ADDR, which ? pong_addr : ping_addr);
  endfunction

  axil_wr_master u_wr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_start (r_start),
    .i_req   (r_req),
    .o_done  (w_wr_done),
    .o_err   (w_wr_err),
    .m_axil  (m_axil)
  );

  // Every WR_* state is entered together with a one-cycle r_start, so the
  // write launches as the state is taken and the state is left on its B beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_cur_buf  <= 1'b0;
      r_start    <= 1'b0;
      r_req      <= '0;
      r_buf_done <= 1'b0;
      r_buf_idx  <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_start    <= 1'b0;
      r_buf_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_WR_CR;
            r_busy  <= 1'b1;
            r_start <= 1'b1;
            r_req   <= make_req(REG_CR, DMACR_RUN_IOC);
          end
        end

        ST_WR_CR: begin
          if (w_wr_done) begin
            r_state <= ST_WR_ADDR;
            r_start <= 1'b1;
            r_req   <= addr_req(r_cur_buf);
          end
        end

        ST_WR_ADDR: begin
          if (w_wr_done) begin
            r_state <= ST_WR_LEN;
            r_start <= 1'b1;
            r_req   <= make_req(REG_LEN, w_len_ext);
          end
        end

        // The LENGTH write starts the transfer; from here only the irq matters.
        ST_WR_LEN: begin
          if (w_wr_done) r_state <= ST_WAIT_IRQ;
        end

        ST_WAIT_IRQ: begin
          if (dma_irq) begin
            r_state <= ST_WR_SR;
            r_start <= 1'b1;
            r_req   <= make_req(REG_SR, DMASR_IOC_CLR);
          end
        end

        // enable is only looked at here, so a buffer already started always
        // reaches its interrupt acknowledge before the loop stops.
        ST_WR_SR: begin
          if (w_wr_done) begin
            r_buf_done <= 1'b1;
            r_buf_idx  <= r_cur_buf;
            r_cur_buf  <= ~r_cur_buf;
            if (enable) begin
              r_state <= ST_WR_ADDR;
              r_start <= 1'b1;
              r_req   <= addr_req(~r_cur_buf);
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        ST_ERROR: begin
          r_busy <= 1'b0;
        end

        default: begin
          r_state <= ST_ERROR;
          r_busy  <= 1'b0;
          r_error <= 1'b1;
        end
      endcase

      // Any rejected write parks the scheduler until reset.
      if (w_wr_err) begin
        r_state <= ST_ERROR;
        r_start <= 1'b0;
        r_busy  <= 1'b0;
        r_error <= 1'b1;
      end
    end
  end

  assign buf_done = r_buf_done;
  assign buf_idx  = r_buf_idx;
  assign busy     = r_busy;
  assign error    = r_error;

endmodule

// File: tb/tb_dma_pingpong_sched.sv
module tb_dma_pingpong_sched;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_CR   = BASE + 32'h30;
  localparam logic [31:0] A_SR   = BASE + 32'h34;
  localparam logic [31:0] A_ADDR = BASE + 32'h48;
  localparam logic [31:0] A_LEN  = BASE + 32'h58;
  localparam logic [31:0] PING   = 32'hC000_0000;
  localparam logic [31:0] PONG   = 32'hC000_4000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        aclk      = 1'b0;
  logic        aresetn   = 1'b0;
  logic        enable    = 1'b0;
  logic        dma_irq   = 1'b0;
  logic [31:0] ping_addr = PING;
  logic [31:0] pong_addr = PONG;
  logic [25:0] xfer_len  = 26'h400;
  logic        buf_done;
  logic        buf_idx;
  logic        busy;
  logic        error;

  dma_pingpong_sched_if m_axil();

  dma_pingpong_sched #(
    .REG_BASE (BASE),
    .DIR_S2MM (1'b1),
    .LEN_W    (26)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .enable    (enable),
    .ping_addr (ping_addr),
    .pong_addr (pong_addr),
    .xfer_len  (xfer_len),
    .dma_irq   (dma_irq),
    .buf_done  (buf_done),
    .buf_idx   (buf_idx),
    .busy      (busy),
    .error     (error),
    .m_axil    (m_axil)
  );

  always #5 aclk = ~aclk;

  int   checks     = 0;
  int   errors     = 0;
  int   wr_cnt     = 0;
  int   done_cnt   = 0;
  int   ready_pct  = 100;
  logic err_arm    = 1'b0;
  logic [31:0] err_addr = '0;
  logic model_cur  = 1'b0;
  logic mon_exp;

  wr_t  exp_wr_q[$];
  logic exp_idx_q[$];

  // ---------------------------------------------------------------------------
  // AXI-Lite slave: random AW/W ready skew, B one cycle after both beats.
  // Readies change on the falling edge, so valid && ready seen there is the
  // handshake of the next rising edge. Each completed write is scored.
  // ---------------------------------------------------------------------------
  initial begin : slave
    logic        aw_got;
    logic        w_got;
    logic        b_fire;
    logic [31:0] cap_addr;
    logic [31:0] cap_data;
    wr_t         e;
    aw_got = 1'b0; w_got = 1'b0; b_fire = 1'b0;
    cap_addr = '0; cap_data = '0;
    m_axil.awready = 1'b0;
    m_axil.wready  = 1'b0;
    m_axil.bvalid  = 1'b0;
    m_axil.bresp   = 2'b00;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        aw_got = 1'b0; w_got = 1'b0; b_fire = 1'b0;
        m_axil.awready = 1'b0;
        m_axil.wready  = 1'b0;
        m_axil.bvalid  = 1'b0;
        m_axil.bresp   = 2'b00;
      end else begin
        if (b_fire) begin
          m_axil.bvalid = 1'b0;
          b_fire = 1'b0;
        end
        if (aw_got && w_got && !m_axil.bvalid) begin
          if (err_arm && cap_addr == err_addr) begin
            m_axil.bresp = 2'b10;
            err_arm = 1'b0;
          end else begin
            m_axil.bresp = 2'b00;
          end
          m_axil.bvalid = 1'b1;
          aw_got = 1'b0;
          w_got  = 1'b0;
          wr_cnt++;
          checks++;
          if (exp_wr_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h", cap_addr, cap_data);
          end else begin
            e = exp_wr_q.pop_front();
            if (cap_addr !== e.addr || cap_data !== e.data) begin
              errors++;
              $display("FAIL write_%0d got %h<-%h expected %h<-%h",
                       wr_cnt, cap_addr, cap_data, e.addr, e.data);
            end
          end
        end
        m_axil.awready = !aw_got && (int'($urandom_range(0, 99)) < ready_pct);
        m_axil.wready  = !w_got  && (int'($urandom_range(0, 99)) < ready_pct);
        if (m_axil.awvalid && m_axil.awready) begin
          aw_got   = 1'b1;
          cap_addr = m_axil.awaddr;
        end
        if (m_axil.wvalid && m_axil.wready) begin
          w_got    = 1'b1;
          cap_data = m_axil.wdata;
        end
        b_fire = m_axil.bvalid && m_axil.bready;
      end
    end
  end

  // buf_done scoreboard: each pulse must match the next expected index.
  always @(negedge aclk) begin
    if (aresetn && buf_done) begin
      done_cnt++;
      checks++;
      if (exp_idx_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_buf_done buf_idx=%0d", buf_idx);
      end else begin
        mon_exp = exp_idx_q.pop_front();
        if (buf_idx !== mon_exp) begin
          errors++;
          $display("FAIL buf_idx got %0d expected %0d", buf_idx, mon_exp);
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // helpers
  // ---------------------------------------------------------------------------
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr_q.push_back(e);
  endtask

  task automatic wait_writes(input int target, input string name);
    int cyc;
    cyc = 0;
    while (wr_cnt < target && cyc < 3000) begin
      @(negedge aclk);
      cyc++;
    end
    checks++;
    if (wr_cnt < target) begin
      errors++;
      $display("FAIL %s timeout writes=%0d expected %0d", name, wr_cnt, target);
    end
  endtask

  // Complete the pending buffer: irq held until the SR write lands, then the
  // follow-up ADDR/LEN writes if enable stays high.
  task automatic do_buffer(input bit cont);
    int start;
    start = wr_cnt;
    push_wr(A_SR, 32'h0000_1000);
    exp_idx_q.push_back(model_cur);
    if (cont) begin
      push_wr(A_ADDR, model_cur ? PING : PONG);
      push_wr(A_LEN, {6'b0, xfer_len});
    end
    dma_irq = 1'b1;
    wait_writes(start + 1, "sr_write");
    dma_irq = 1'b0;
    model_cur = ~model_cur;
    if (cont) wait_writes(start + 3, "next_buffer_writes");
  endtask

  // ---------------------------------------------------------------------------
  // tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({busy, error, buf_done, m_axil.awvalid, m_axil.wvalid, m_axil.bready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b expected 000000",
               {busy, error, buf_done, m_axil.awvalid, m_axil.wvalid, m_axil.bready});
    end
    checks++;
    if (m_axil.awaddr !== 32'h0 || m_axil.wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus awaddr=%h wdata=%h expected 0", m_axil.awaddr, m_axil.wdata);
    end
    checks++;
    if (m_axil.wstrb !== 4'hF) begin
      errors++;
      $display("FAIL wstrb got %h expected f", m_axil.wstrb);
    end
  endtask

  task automatic test_first_buffer();
    push_wr(A_CR, 32'h0000_1001);
    push_wr(A_ADDR, PING);
    push_wr(A_LEN, 32'h0000_0400);
    aresetn = 1'b1;
    @(negedge aclk);
    enable = 1'b1;
    wait_writes(3, "startup_writes");
    repeat (20) @(negedge aclk);
    checks++;
    if (wr_cnt !== 3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_irq_idle writes=%0d busy=%0d expected 3 and 1", wr_cnt, busy);
    end
    do_buffer(1'b1);
    repeat (5) @(negedge aclk);
    checks++;
    if (done_cnt !== 1 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL first_done done=%0d pending=%0d expected 1 and 0",
               done_cnt, exp_wr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    ready_pct = 50;
    for (int i = 0; i < 8; i++) begin
      xfer_len = 26'h100 + 26'(i * 'h40);
      do_buffer(1'b1);
      repeat (int'($urandom_range(0, 4))) @(negedge aclk);
    end
    repeat (10) @(negedge aclk);
    checks++;
    if (done_cnt - d0 !== 8 || exp_idx_q.size() != 0 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back done=%0d expected 8 (pending wr=%0d idx=%0d)",
               done_cnt - d0, exp_wr_q.size(), exp_idx_q.size());
    end
    ready_pct = 100;
  endtask

  task automatic test_enable_drop();
    int w0;
    enable = 1'b0;
    do_buffer(1'b0);
    w0 = wr_cnt;
    repeat (30) @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || wr_cnt !== w0 || exp_idx_q.size() != 0) begin
      errors++;
      $display("FAIL enable_drop busy=%0d extra_writes=%0d expected 0 and 0",
               busy, wr_cnt - w0);
    end
    push_wr(A_CR, 32'h0000_1001);
    push_wr(A_ADDR, model_cur ? PONG : PING);
    push_wr(A_LEN, {6'b0, xfer_len});
    enable = 1'b1;
    wait_writes(w0 + 3, "reenable_writes");
    repeat (5) @(negedge aclk);
    checks++;
    if (busy !== 1'b1 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL reenable busy=%0d pending=%0d expected 1 and 0", busy, exp_wr_q.size());
    end
  endtask

  task automatic test_error();
    int w0;
    err_arm  = 1'b1;
    err_addr = A_LEN;
    do_buffer(1'b1);
    repeat (10) @(negedge aclk);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL slverr_state error=%0d busy=%0d expected 1 and 0", error, busy);
    end
    w0 = wr_cnt;
    dma_irq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      enable = ~enable;
      repeat (5) @(negedge aclk);
    end
    enable  = 1'b1;
    repeat (10) @(negedge aclk);
    checks++;
    if (wr_cnt !== w0 || m_axil.awvalid !== 1'b0 || error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL error_absorbing writes=%0d awvalid=%0d error=%0d busy=%0d expected 0 0 1 0",
               wr_cnt - w0, m_axil.awvalid, error, busy);
    end
    dma_irq = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    int w0;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    exp_wr_q.delete();
    exp_idx_q.delete();
    model_cur = 1'b0;
    ready_pct = 0;
    aresetn   = 1'b1;
    cyc = 0;
    while (m_axil.awvalid !== 1'b1 && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    checks++;
    if (m_axil.awvalid !== 1'b1) begin
      errors++;
      $display("FAIL stalled_awvalid got %0d expected 1", m_axil.awvalid);
    end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({busy, error, buf_done, m_axil.awvalid, m_axil.wvalid, m_axil.bready} !== 6'b0
        || m_axil.awaddr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset flags=%b awaddr=%h expected 000000 and 0",
               {busy, error, buf_done, m_axil.awvalid, m_axil.wvalid, m_axil.bready},
               m_axil.awaddr);
    end
    repeat (2) @(negedge aclk);
    ready_pct = 100;
    w0 = wr_cnt;
    push_wr(A_CR, 32'h0000_1001);
    push_wr(A_ADDR, PING);
    push_wr(A_LEN, {6'b0, xfer_len});
    aresetn = 1'b1;
    wait_writes(w0 + 3, "restart_writes");
    repeat (5) @(negedge aclk);
    checks++;
    if (busy !== 1'b1 || error !== 1'b0 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL restart busy=%0d error=%0d pending=%0d expected 1 0 0",
               busy, error, exp_wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_first_buffer();
    test_back_to_back();
    test_enable_drop();
    test_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_pingpong_sched.md
Name: dma_pingpong_sched

Overview:
- AXI4-Lite master that sequences one Xilinx AXI DMA channel in simple (non-SG) mode, alternating between a ping and a pong buffer without processor involvement.
- Programs DMACR once, then repeatedly writes address and LENGTH, waits for the DMA completion interrupt, acknowledges it and swaps buffers.
- One instance sits beside each DMA (I2S, FFT TX, FFT RX, VGA) on the PL side, on the same AXI-Lite interconnect the PS uses for DMA registers.

Parameters:
- REG_BASE, 32'h4000_0000, AXI-Lite base address of the controlled DMA.
- DIR_S2MM, 1, 1 = program the S2MM channel (regs 0x30/0x34/0x48/0x58); 0 = MM2S (0x00/0x04/0x18/0x28).
- LEN_W, 26, width of the DMA LENGTH field in bytes.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run ping/pong loop, 0 = stop after the current buffer.
- ping_addr  in  32  ping buffer byte address; sampled at each ADDR write.
- pong_addr  in  32  pong buffer byte address; sampled at each ADDR write.
- xfer_len  in  LEN_W  bytes per buffer; sampled at each LEN write.
- dma_irq  in  1  DMA channel interrupt, level high.
- buf_done  out  1  one-cycle pulse when a buffer completes.
- buf_idx  out  1  buffer just completed (0 = ping, 1 = pong); valid with buf_done.
- busy  out  1  high in every state except IDLE and ERROR.
- error  out  1  sticky; set on a non-OKAY BRESP.
- m_axil_awaddr  out  32;  m_axil_awvalid  out  1;  m_axil_awready  in  1.
- m_axil_wdata  out  32;  m_axil_wstrb  out  4 (always 4'hF);  m_axil_wvalid  out  1;  m_axil_wready  in  1.
- m_axil_bresp  in  2;  m_axil_bvalid  in  1;  m_axil_bready  out  1.

Behaviour:
- Reset (async assert, sync release): state IDLE, cur_buf=0, all valids/bready/buf_done/busy/error = 0, awaddr/wdata = 0.
- Register write primitive (states WR_*):
  - awvalid and wvalid assert together on state entry.
  - Each drops independently on its own ready handshake; the two may complete in either order or in the same cycle.
  - bready is held high until bvalid.
  - awaddr/wdata are stable while the respective valid is high.
  - After B: bresp == 2'b00 → next state; otherwise → ERROR.
- States:
  - IDLE: enable=1 → WR_CR.
  - WR_CR: data 32'h0000_1001 (RS, IOC_IrqEn) to DMACR → WR_ADDR.
  - WR_ADDR: cur_buf ? pong_addr : ping_addr, to SA/DA → WR_LEN.
  - WR_LEN: {zero-ext xfer_len} to LENGTH, which starts the transfer → WAIT_IRQ.
  - WAIT_IRQ: dma_irq=1 → WR_SR.
  - WR_SR: 32'h0000_1000 to DMASR (W1C IOC). On B okay:
    - buf_done=1 for one cycle with buf_idx=cur_buf, then cur_buf toggles.
    - enable=1 → WR_ADDR (DMACR is not rewritten); else → IDLE.
  - ERROR: absorbing; error=1, busy=0; left only by reset.
- enable falling mid-sequence: the current buffer is carried to completion through WR_SR. It is never aborted.
- dma_irq before WAIT_IRQ is ignored until WAIT_IRQ. A still-high level after the SR write is not re-consumed: WR_SR lasts ≥2 cycles and the DMA drops irq after the W1C.
- xfer_len == 0: written as-is; the DMA flags an error, which is outside this block's scope.
- From IDLE, cur_buf is retained (it is not reset to ping on re-enable); only aresetn clears it.
- Throughput: at most one outstanding AXI-Lite transaction. With zero-wait slaves each write takes 3 cycles (valid, handshake+B, next).

Decomposition:
- Package dma_sched_pkg holds:
  - state enum;
  - DMA register offsets for MM2S/S2MM simple mode;
  - DMACR_RUN_IOC = 32'h1001, DMASR_IOC_CLR = 32'h1000;
  - RESP_OKAY = 2'b00.
- One sub-module, axil_wr_master: the single-write primitive with start/done/err, addr/data in and the AW/W/B ports.
- The FSM wrapper instantiates it.

Test Plan:
- Reset, then enable=1 (S2MM, base 0x4000_0000, ping 0xC000_0000, pong 0xC000_4000, len 0x400) → writes in order: 0x4000_0030←0x1001, 0x4000_0048←0xC000_0000, 0x4000_0058←0x400; then idle until irq.
- Pulse dma_irq (held until SR write) → 0x4000_0034←0x1000, buf_done pulse with buf_idx=0, then 0x4000_0048←0xC000_4000 and LENGTH←0x400; no DMACR rewrite.
- Slave with randomized awready/wready skew (W before AW, AW before W, same cycle) over 8 buffers → addresses alternate ping/pong, 8 buf_done pulses, buf_idx 0,1,0,1…
- Drop enable during WAIT_IRQ, then irq → SR write and buf_done occur, state returns to IDLE, busy=0, no further writes. Re-enable → next ADDR write uses the toggled buffer.
- bresp=2'b10 on the LEN write → error=1, busy=0, no further AW. irq and enable are ignored until aresetn.
- Assert aresetn=0 mid-handshake (awvalid high) → all outputs 0 asynchronously. After release with enable=1 the sequence restarts at WR_CR with the ping address.
